// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C SCL generator and the SDA/bit engine that
// follows its phase ticks.
//   scl_state_t  : SCL generator FSM states
//   SCL_MIN_DIV  : smallest SCL period (clk cycles) the generator will run
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int SCL_MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_HOLD = 3'd1,
    LOW        = 3'd2,
    REL_WAIT   = 3'd3,
    HIGH       = 3'd4
  } scl_state_t;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen_if
// Bundles the controller-side and pad-side signals of the SCL generator.
//   master modport : the generator (drives pad control, status and ticks)
//   slave  modport : controller + IOBUF side (drives run/config, pad value)
// Signals:
//   en, div, high_cnt, to_lim          run request and timing configuration
//   i2c_scl_i, i2c_scl_t, i2c_scl_o    IOBUF I / T / O
//   busy, stretching, timeout          status
//   fall/change/rise/sample_tick       single-cycle phase ticks
//   counter                            current phase counter
// -----------------------------------------------------------------------------
interface i2c_scl_gen_if #(
  parameter int DIV_LEN = 16,
  parameter int TO_LEN  = 20
);
  logic               en;
  logic [DIV_LEN-1:0] div;
  logic [DIV_LEN-1:0] high_cnt;
  logic [TO_LEN-1:0]  to_lim;
  logic               i2c_scl_i;
  logic               i2c_scl_t;
  logic               i2c_scl_o;
  logic               busy;
  logic               fall_tick;
  logic               change_tick;
  logic               rise_tick;
  logic               sample_tick;
  logic               stretching;
  logic               timeout;
  logic [DIV_LEN-1:0] counter;

  modport master (
    input  en, div, high_cnt, to_lim, i2c_scl_o,
    output i2c_scl_i, i2c_scl_t, busy, fall_tick, change_tick, rise_tick,
           sample_tick, stretching, timeout, counter
  );

  modport slave (
    output en, div, high_cnt, to_lim, i2c_scl_o,
    input  i2c_scl_i, i2c_scl_t, busy, fall_tick, change_tick, rise_tick,
           sample_tick, stretching, timeout, counter
  );
endinterface

// File: rtl/i2c_sync.sv
// -----------------------------------------------------------------------------
// i2c_sync
// STAGES-deep flop synchronizer for an asynchronous pad input (SCL or SDA).
//   clk, rstn : clock, asynchronous active-low reset
//   d_i       : asynchronous input
//   q_o       : synchronized value
//   q_nxt_o   : value q_o will take after the next clock edge (look-ahead)
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module i2c_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o,
  output logic q_nxt_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; stage 0 is the metastability-catching flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o     = sync_q[STAGES-1];
  assign q_nxt_o = sync_q[STAGES-2];

endmodule

// File: rtl/i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen
// Open-drain I2C SCL generator with programmable period/high time, slave
// clock-stretch support with timeout, and single-cycle phase ticks.
//   clk, rstn : system clock, asynchronous active-low reset
//   bus       : i2c_scl_gen_if.master
//     en / div / high_cnt / to_lim : run request and timing (to_lim 0 = off)
//     i2c_scl_i (tied 0), i2c_scl_t (1 = released), i2c_scl_o (pad, async)
//     busy, stretching, timeout (sticky), counter
//     fall_tick, change_tick, rise_tick, sample_tick
// All outputs are registered and reflect the state they belong to.
// -----------------------------------------------------------------------------
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV_LEN     = 16,
  parameter int TO_LEN      = 20,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rstn,
  i2c_scl_gen_if.master bus
);

  localparam logic [DIV_LEN-1:0] DIV_ZERO = {DIV_LEN{1'b0}};
  localparam logic [DIV_LEN-1:0] DIV_ONE  = {{(DIV_LEN-1){1'b0}}, 1'b1};
  localparam logic [DIV_LEN-1:0] DIV_TWO  = {{(DIV_LEN-2){1'b0}}, 2'b10};
  localparam logic [DIV_LEN-1:0] DIV_MAX  = {DIV_LEN{1'b1}};
  localparam logic [DIV_LEN-1:0] DIV_MIN  = DIV_LEN'(SCL_MIN_DIV);
  localparam logic [TO_LEN-1:0]  TO_ZERO  = {TO_LEN{1'b0}};
  localparam logic [TO_LEN-1:0]  TO_ONE   = {{(TO_LEN-1){1'b0}}, 1'b1};
  localparam logic [TO_LEN-1:0]  TO_MAX   = {TO_LEN{1'b1}};
  localparam logic [TO_LEN-1:0]  SYNC_LIM = TO_LEN'(SYNC_STAGES);

  // Period clamp: never shorter than the minimum legal period.
  function automatic logic [DIV_LEN-1:0] clamp_div(input logic [DIV_LEN-1:0] d);
    if (d < DIV_MIN) begin
      return DIV_MIN;
    end else begin
      return d;
    end
  endfunction

  // High-time clamp: 1 .. div_l-2, so the low phase is always >= 2 cycles.
  function automatic logic [DIV_LEN-1:0] clamp_hi(input logic [DIV_LEN-1:0] h,
                                                  input logic [DIV_LEN-1:0] dl);
    logic [DIV_LEN-1:0] r;
    r = h;
    if (r > (dl - DIV_TWO)) begin
      r = dl - DIV_TWO;
    end else begin
      r = h;
    end
    if (r == DIV_ZERO) begin
      r = DIV_ONE;
    end else begin
      r = r;
    end
    return r;
  endfunction

  scl_state_t         state_q, state_d;
  logic [DIV_LEN-1:0] cnt_q, cnt_d;
  logic [TO_LEN-1:0]  wait_q, wait_d;
  logic [DIV_LEN-1:0] div_l_q, div_l_d;
  logic [DIV_LEN-1:0] hi_l_q, hi_l_d;
  logic               t_q, t_d;
  logic               busy_q, busy_d;
  logic               fall_q, fall_d;
  logic               change_q, change_d;
  logic               rise_q, rise_d;
  logic               sample_q, sample_d;
  logic               stretch_q, stretch_d;
  logic               timeout_q, timeout_d;

  logic               scl_s;
  logic               scl_nxt_s;
  logic [DIV_LEN-1:0] div_lat_s;
  logic [DIV_LEN-1:0] hi_lat_s;
  logic [DIV_LEN-1:0] lo_len_s;
  logic [DIV_LEN-1:0] lo_nxt_s;

  i2c_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_scl_sync (
    .clk     (clk),
    .rstn    (rstn),
    .d_i     (bus.i2c_scl_o),
    .q_o     (scl_s),
    .q_nxt_o (scl_nxt_s)
  );

  assign div_lat_s = clamp_div(bus.div);
  assign hi_lat_s  = clamp_hi(bus.high_cnt, div_lat_s);
  assign lo_len_s  = div_l_q - hi_l_q;

  // Next-state, counters, latched timing and the registered outputs' next values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    div_l_d   = div_l_q;
    hi_l_d    = hi_l_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        cnt_d  = DIV_ZERO;
        wait_d = TO_ZERO;
        if (!bus.en) begin
          timeout_d = 1'b0;
        end else begin
          timeout_d = timeout_q;
        end
        if (bus.en && !timeout_q) begin
          state_d = START_HOLD;
          div_l_d = div_lat_s;
          hi_l_d  = hi_lat_s;
        end else begin
          state_d = IDLE;
        end
      end
      START_HOLD: begin
        if (cnt_q == hi_l_q - DIV_ONE) begin
          state_d = LOW;
          cnt_d   = DIV_ZERO;
          div_l_d = div_lat_s;
          hi_l_d  = hi_lat_s;
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end
      LOW: begin
        if (cnt_q == lo_len_s - DIV_ONE) begin
          state_d = REL_WAIT;
          cnt_d   = DIV_ZERO;
          wait_d  = TO_ZERO;
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end
      REL_WAIT: begin
        // The look-ahead tap lets HIGH start on the very cycle scl_s first
        // reads 1, so the synchronizer latency is part of the release wait.
        // scl_s itself is only a backstop in case the edge was missed.
        if (scl_nxt_s || scl_s) begin
          state_d = HIGH;
          cnt_d   = DIV_ZERO;
        end else if ((bus.to_lim != TO_ZERO) && (wait_q >= bus.to_lim - TO_ONE)) begin
          state_d   = IDLE;
          cnt_d     = DIV_ZERO;
          timeout_d = 1'b1;
        end else begin
          wait_d = (wait_q == TO_MAX) ? wait_q : wait_q + TO_ONE;
          cnt_d  = (cnt_q == DIV_MAX) ? cnt_q : cnt_q + DIV_ONE;
        end
      end
      HIGH: begin
        if (cnt_q == hi_l_q - DIV_ONE) begin
          cnt_d = DIV_ZERO;
          if (bus.en) begin
            state_d = LOW;
            div_l_d = div_lat_s;
            hi_l_d  = hi_lat_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = DIV_ZERO;
        wait_d  = TO_ZERO;
      end
    endcase

    lo_nxt_s  = div_l_d - hi_l_d;
    t_d       = (state_d != LOW);
    busy_d    = (state_d != IDLE);
    fall_d    = (state_d == LOW) && (state_q != LOW);
    change_d  = (state_d == LOW) && (state_q == LOW) && (cnt_d == (lo_nxt_s >> 1));
    rise_d    = (state_d == HIGH) && (state_q == REL_WAIT);
    // With hi_l = 1 the sample point would land on the rise; the rise wins.
    sample_d  = (state_d == HIGH) && !rise_d && (cnt_d == (hi_l_d >> 1));
    stretch_d = (state_d == REL_WAIT) && (wait_d >= SYNC_LIM);
  end

  // State, counters and registered outputs; reset releases SCL at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= DIV_ZERO;
      wait_q    <= TO_ZERO;
      div_l_q   <= DIV_MIN;
      hi_l_q    <= DIV_ONE;
      t_q       <= 1'b1;
      busy_q    <= 1'b0;
      fall_q    <= 1'b0;
      change_q  <= 1'b0;
      rise_q    <= 1'b0;
      sample_q  <= 1'b0;
      stretch_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      div_l_q   <= div_l_d;
      hi_l_q    <= hi_l_d;
      t_q       <= t_d;
      busy_q    <= busy_d;
      fall_q    <= fall_d;
      change_q  <= change_d;
      rise_q    <= rise_d;
      sample_q  <= sample_d;
      stretch_q <= stretch_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.i2c_scl_i   = 1'b0;
  assign bus.i2c_scl_t   = t_q;
  assign bus.busy        = busy_q;
  assign bus.fall_tick   = fall_q;
  assign bus.change_tick = change_q;
  assign bus.rise_tick   = rise_q;
  assign bus.sample_tick = sample_q;
  assign bus.stretching  = stretch_q;
  assign bus.timeout     = timeout_q;
  assign bus.counter     = cnt_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// tb_i2c_scl_gen
// Directed bench for i2c_scl_gen. The pad follows i2c_scl_t through a pull-up
// unless the bench holds it low to emulate a stretching slave.
// -----------------------------------------------------------------------------
module tb_i2c_scl_gen;

  localparam int DIV_LEN = 16;
  localparam int TO_LEN  = 20;
  localparam int SYNC    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic hold = 1'b0;

  i2c_scl_gen_if #(.DIV_LEN(DIV_LEN), .TO_LEN(TO_LEN)) bus ();

  i2c_scl_gen #(
    .DIV_LEN     (DIV_LEN),
    .TO_LEN      (TO_LEN),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  // Open-drain pad: driven to I when T=0, else pulled up unless held low.
  assign bus.i2c_scl_o = bus.i2c_scl_t ? ~hold : bus.i2c_scl_i;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_stretch = 0;
  int n_multi   = 0;
  int fall_t[$];
  int rise_t[$];
  int chg_t[$];
  int chg_v[$];
  int smp_t[$];
  int smp_v[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Records tick times/counter values, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.fall_tick) fall_t.push_back(cyc);
    if (bus.rise_tick) rise_t.push_back(cyc);
    if (bus.change_tick) begin chg_t.push_back(cyc); chg_v.push_back(int'(bus.counter)); end
    if (bus.sample_tick) begin smp_t.push_back(cyc); smp_v.push_back(int'(bus.counter)); end
    if (bus.stretching) n_stretch++;
    if ((32'(bus.fall_tick) + 32'(bus.change_tick) + 32'(bus.rise_tick) + 32'(bus.sample_tick)) > 1) n_multi++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    fall_t.delete(); rise_t.delete(); chg_t.delete(); chg_v.delete();
    smp_t.delete(); smp_v.delete(); n_stretch = 0;
  endtask

  task automatic wait_falls(input int n, input int budget, input string tag);
    int k = 0;
    while (fall_t.size() < n && k < budget) begin step(); k++; end
    check_eq(tag, fall_t.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (bus.busy && k < budget) begin step(); k++; end
    check_eq(tag, bus.busy, 0);
  endtask

  function automatic int ticks();
    return int'({bus.fall_tick, bus.change_tick, bus.rise_tick, bus.sample_tick});
  endfunction

  initial begin
    int en_t;
    int k;
    int busy_seen;
    bus.en = 1'b0; bus.div = 16'd10; bus.high_cnt = 16'd5; bus.to_lim = 20'd0;
    repeat (3) step();
    check_eq("rst_t", bus.i2c_scl_t, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_cnt", bus.counter, 0);
    check_eq("rst_ticks", ticks(), 0);
    check_eq("rst_timeout", bus.timeout, 0);
    check_eq("rst_stretch", bus.stretching, 0);
    rstn = 1'b1;
    step(); step();

    // Nominal run: div=10, high=5.
    clear_mon();
    en_t = cyc; bus.en = 1'b1;
    wait_falls(4, 100, "t1_wait_falls");
    check_eq("t1_first_fall", fall_t[0] - en_t, 6);
    check_eq("t1_spacing1", fall_t[1] - fall_t[0], 12);
    check_eq("t1_spacing2", fall_t[2] - fall_t[1], 12);
    check_eq("t1_low_len", rise_t[0] - fall_t[0], 7);
    check_eq("t1_high_len", fall_t[1] - rise_t[0], 5);
    check_eq("t1_change_cnt", chg_v[0], 2);
    check_eq("t1_change_ofs", chg_t[0] - fall_t[0], 2);
    check_eq("t1_sample_cnt", smp_v[0], 2);
    check_eq("t1_sample_ofs", smp_t[0] - rise_t[0], 2);
    check_eq("t1_no_stretch", n_stretch, 0);
    bus.en = 1'b0;
    wait_idle(40, "t1_idle");

    // Stretch 12 cycles past release, no timeout.
    clear_mon();
    bus.en = 1'b1;
    wait_falls(1, 40, "t2_wait_fall");
    k = 0;
    while (!bus.i2c_scl_t && k < 20) begin step(); k++; end
    check_eq("t2_released", bus.i2c_scl_t, 1);
    hold = 1'b1;
    repeat (12) step();
    hold = 1'b0;
    wait_falls(2, 60, "t2_wait_fall2");
    check_eq("t2_stretch_len", n_stretch, 12);
    check_eq("t2_rises", rise_t.size(), 1);
    check_eq("t2_fall_to_rise", rise_t[0] - fall_t[0], 19);
    check_eq("t2_high_len", fall_t[1] - rise_t[0], 5);
    check_eq("t2_timeout", bus.timeout, 0);
    bus.en = 1'b0;
    wait_idle(40, "t2_idle");

    // Pad stuck low, to_lim=20.
    clear_mon();
    bus.to_lim = 20'd20;
    bus.en = 1'b1;
    wait_falls(1, 40, "t3_wait_fall");
    hold = 1'b1;
    n_stretch = 0;
    k = 0;
    while (!bus.timeout && k < 60) begin step(); k++; end
    check_eq("t3_timeout_set", bus.timeout, 1);
    check_eq("t3_timeout_time", cyc - fall_t[0], 25);
    check_eq("t3_t_released", bus.i2c_scl_t, 1);
    check_eq("t3_busy", bus.busy, 0);
    check_eq("t3_stretch_len", n_stretch, 18);
    busy_seen = 0;
    repeat (10) begin step(); busy_seen |= int'(bus.busy); end
    check_eq("t3_en_ignored", busy_seen, 0);
    check_eq("t3_sticky", bus.timeout, 1);
    check_eq("t3_no_refall", fall_t.size(), 1);
    hold = 1'b0;
    bus.en = 1'b0;
    step();
    check_eq("t3_cleared", bus.timeout, 0);
    bus.to_lim = 20'd0;
    step();

    // en drops on the second LOW cycle: period completes.
    clear_mon();
    bus.en = 1'b1;
    wait_falls(1, 40, "t4_wait_fall");
    step();
    bus.en = 1'b0;
    wait_idle(40, "t4_idle");
    check_eq("t4_idle_time", cyc - fall_t[0], 12);
    repeat (5) step();
    check_eq("t4_falls", fall_t.size(), 1);
    check_eq("t4_rises", rise_t.size(), 1);
    check_eq("t4_t_released", bus.i2c_scl_t, 1);

    // div 10 -> 20 mid-LOW.
    clear_mon();
    bus.en = 1'b1;
    wait_falls(1, 40, "t5_wait_fall");
    step();
    bus.div = 16'd20;
    wait_falls(3, 100, "t5_wait_falls");
    check_eq("t5_old_period", fall_t[1] - fall_t[0], 12);
    check_eq("t5_new_period", fall_t[2] - fall_t[1], 22);
    check_eq("t5_change_old", chg_v[0], 2);
    check_eq("t5_change_new", chg_v[1], 7);
    bus.en = 1'b0;
    wait_idle(60, "t5_idle");
    bus.div = 16'd10;

    // Illegal config div=3, high=9 -> div_l=4, hi_l=2.
    clear_mon();
    bus.div = 16'd3; bus.high_cnt = 16'd9;
    en_t = cyc; bus.en = 1'b1;
    wait_falls(2, 60, "t6_wait_falls");
    check_eq("t6_first_fall", fall_t[0] - en_t, 3);
    check_eq("t6_period", fall_t[1] - fall_t[0], 6);
    check_eq("t6_low_len", rise_t[0] - fall_t[0], 4);
    check_eq("t6_change_cnt", chg_v[0], 1);
    check_eq("t6_sample_cnt", smp_v[0], 1);
    bus.en = 1'b0;
    wait_idle(40, "t6_idle");
    bus.div = 16'd10; bus.high_cnt = 16'd5;

    // Asynchronous reset mid-HIGH, then mid-LOW.
    clear_mon();
    bus.en = 1'b1;
    k = 0;
    while (rise_t.size() < 1 && k < 60) begin step(); k++; end
    check_eq("t7_wait_rise", rise_t.size(), 1);
    step();
    check_eq("t7_pre_cnt", bus.counter, 1);
    rstn = 1'b0;
    #1;
    check_eq("t7h_cnt", bus.counter, 0);
    check_eq("t7h_busy", bus.busy, 0);
    check_eq("t7h_t", bus.i2c_scl_t, 1);
    step();
    rstn = 1'b1;
    clear_mon();
    wait_falls(1, 40, "t7_wait_fall");
    step();
    check_eq("t7_pre_low", bus.i2c_scl_t, 0);
    rstn = 1'b0;
    #1;
    check_eq("t7l_t", bus.i2c_scl_t, 1);
    check_eq("t7l_busy", bus.busy, 0);
    check_eq("t7l_cnt", bus.counter, 0);
    check_eq("t7l_ticks", ticks(), 0);
    bus.en = 1'b0;
    step();
    rstn = 1'b1;
    repeat (3) step();
    check_eq("t7_stays_idle", bus.busy, 0);

    check_eq("one_tick_max", n_multi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
- Parametrised I2C SCL generator.
- Open-drain: drives SCL low, or releases it.
- Runtime-programmable period and high time.
- Supports slave clock stretching, with a timeout.
- Emits single-cycle phase ticks (fall, change, rise, sample) for the byte/bit engine that drives SDA.
- Sits between the IOBUF on the SCL pad and the I2C master controller FSM.

Parameters:
- DIV_LEN, 16: width of the period, high-time and phase-counter fields.
- TO_LEN, 20: width of the stretch-timeout counter and limit.
- SYNC_STAGES, 2: flops in the SCL input synchronizer (>=2).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- en  input  1  run request from the controller
- div  input  DIV_LEN  SCL period in clk cycles (>=4)
- high_cnt  input  DIV_LEN  high-phase length in clk cycles (1..div-2)
- to_lim  input  TO_LEN  stretch timeout in clk cycles; 0 = disabled
- i2c_scl_i  output  1  value to IOBUF I; tied 0
- i2c_scl_t  output  1  IOBUF tristate; 1 = released, 0 = drive low
- i2c_scl_o  input  1  pad value from IOBUF O (asynchronous)
- busy  output  1  FSM not in IDLE
- fall_tick  output  1  first cycle SCL is driven low
- change_tick  output  1  midpoint of low phase; SDA may change
- rise_tick  output  1  first cycle synchronized SCL reads high
- sample_tick  output  1  midpoint of high phase; SDA sample point
- stretching  output  1  released but bus still low
- timeout  output  1  sticky stretch-timeout flag
- counter  output  DIV_LEN  current phase counter

Behaviour:
- Reset (async, rstn=0): state IDLE; i2c_scl_t=1; i2c_scl_i=0; counter=0; all ticks 0; busy=0; stretching=0; timeout=0; synchronizer flops=1.
- Everything else is registered on posedge clk.
- scl_s = output of the synchronizer on i2c_scl_o. Its latency of SYNC_STAGES cycles counts toward the release wait.
- States: IDLE, START_HOLD, LOW, REL_WAIT, HIGH.
- IDLE:
  - t=1, counter=0.
  - en=1 and timeout=0 -> START_HOLD.
- START_HOLD:
  - t=1, holds for hi_l cycles (tHD;STA, while the controller has SDA low).
  - Then -> LOW.
- div and high_cnt latching:
  - Latched into div_l / hi_l on entry to START_HOLD and on every entry to LOW.
  - Mid-period changes take effect at the next period only.
- LOW:
  - t=0; lo_len = div_l - hi_l.
  - fall_tick on the entry cycle (counter=0).
  - change_tick when counter = lo_len>>1.
  - At counter = lo_len-1 -> REL_WAIT.
- REL_WAIT:
  - t=1; counter is reset and counts wait cycles.
  - scl_s=1 -> HIGH, with rise_tick in that same cycle.
  - stretching=1 while in REL_WAIT with scl_s=0 for more than SYNC_STAGES cycles.
  - to_lim≠0 and wait count reaches to_lim -> timeout=1, -> IDLE (released).
- HIGH:
  - t=1; counts from the rise, so stretch time does not shorten the high phase.
  - sample_tick when counter = hi_l>>1.
  - At counter = hi_l-1: en=1 -> LOW; en=0 -> IDLE.
  - SCL is therefore left high for the STOP condition.
- en deasserted mid-period: the current period always completes. No runt pulse; SCL is always left released.
- Spurious low during HIGH (another master, or glitch): ignored. Arbitration is out of scope.
- timeout is cleared only by en=0 (in IDLE) or by reset. While timeout=1, en is ignored.
- Simultaneous timeout and scl_s rising: the rise wins -> HIGH, no timeout.
- Reset mid-operation: immediate release (t=1) asynchronously. No tick is emitted.
- Illegal configuration (div<4 or high_cnt outside 1..div-2):
  - Clamped at latch time: hi_l = max(1, min(high_cnt, div_l-2)), div_l = max(div, 4).
- At most one tick is high in any cycle. The counter wraps never; phase limits bound it.

Decomposition:
- Package i2c_pkg:
  - typedef enum logic [2:0] scl_state_t {IDLE, START_HOLD, LOW, REL_WAIT, HIGH}.
  - Constant SCL_MIN_DIV=4.
  - Shared by the SDA/bit engine.
- Sub-module i2c_sync: SYNC_STAGES-deep flop synchronizer with parametrised reset value. It is reused for SDA.

Test Plan:
- div=10, high_cnt=5, en held 1, pad follows t:
  - fall_tick every 10+SYNC_STAGES cycles; low 5 cycles.
  - change_tick at low count 2, sample_tick at high count 2.
- Pad held low 12 extra cycles after release, to_lim=0:
  - stretching=1 for the stretch; rise_tick on first scl_s=1.
  - HIGH still lasts 5 cycles; no timeout.
- Pad held low forever, to_lim=20:
  - timeout=1 after 20 wait cycles, t=1, busy=0; en re-pulse ignored.
  - en=0 clears timeout.
- en drops on the 2nd LOW cycle:
  - Period completes (rest of LOW, REL_WAIT, 5 HIGH cycles) then IDLE with t=1; no extra fall_tick.
- div changed 10->20 mid-LOW:
  - Current period stays 10.
  - Next fall→fall spacing is 20+SYNC_STAGES (high_cnt=5 -> low 15).
- div=3, high_cnt=9: clamped to div_l=4, hi_l=2 -> low 2, high 2.
- rstn asserted mid-HIGH and mid-LOW: t=1 immediately (same cycle, async); all outputs at reset values.
